// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue between the fetch front end and decode
//
// Purpose: issues sequential word-aligned fetches to a 1-cycle-latency instruction
// memory, buffers returned {pc, instr} pairs in a DEPTH-entry FIFO and hands them to
// decode over a valid/ready handshake. A redirect flushes the queue and restarts fetch
// at the target; responses to requests issued before the redirect are dropped by epoch.
//
// Optional feature: define FQ_BYPASS_EN to let a response go straight to decode
// when the FIFO is empty (1-cycle request-to-decode latency instead of 2).
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-low reset
//   redirect_valid taken branch/jump, highest priority
//   redirect_pc    redirect target, low two bits ignored
//   imem_req       fetch request this cycle
//   imem_addr      word-aligned fetch address
//   imem_rvalid    response valid, one cycle after the request
//   imem_rdata     returned instruction
//   out_valid      head entry available to decode
//   out_ready      decode accepts head entry
//   out_pc         PC of head entry (0 when out_valid=0)
//   out_instr      instruction of head entry (NOP when out_valid=0)
module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam int              PW  = $clog2(DEPTH);
  localparam int              CW  = PW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q;
  logic            inflight_q;
  logic            tag_q;
  logic            epoch_q;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic          issue, resp_ok, push, pop;
  logic [CW:0]   occupancy;

  // Credit check counts the outstanding request so a response always has a slot.
  // Gating with rst keeps imem_req low while reset is held.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue     = rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    resp_ok   = imem_rvalid && inflight_q && (tag_q == epoch_q);
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = NOP;
    push      = 1'b0;
    pop       = 1'b0;
    if (!redirect_valid) begin
      if (count_q != '0) begin
        out_valid = 1'b1;
        out_pc    = pc_mem_q[rd_ptr_q];
        out_instr = instr_mem_q[rd_ptr_q];
        pop       = out_ready;
        push      = resp_ok;
      end
`ifdef FQ_BYPASS_EN
      else if (resp_ok) begin
        // Empty queue: present the response directly; only store it if decode stalls.
        out_valid = 1'b1;
        out_pc    = req_pc_q;
        out_instr = imem_rdata;
        push      = !out_ready;
      end
`else
      else begin
        push = resp_ok;
      end
`endif
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      count_d    = '0;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
      epoch_q    <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      inflight_q <= issue;
      if (issue) begin
        tag_q    <= epoch_q;
        req_pc_q <= fetch_pc_q;
      end
      if (redirect_valid) begin
        epoch_q  <= ~epoch_q;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed scoreboard testbench for fetch_queue
module tb_fetch_queue;

  localparam logic [31:0] PAT  = 32'hA5A5_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] WRAP = 32'hFFFF_FFF8;
`ifdef FQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect_valid, imem_rvalid, out_ready, sel;
  logic [31:0] redirect_pc, imem_rdata;
  logic        a_req, w_req, a_ov, w_ov;
  logic [31:0] a_addr, w_addr, a_pc, w_pc, a_in, w_in;
  logic        o_req, o_ov;
  logic [31:0] o_addr, o_pc, o_in;

  assign o_req  = sel ? w_req  : a_req;
  assign o_addr = sel ? w_addr : a_addr;
  assign o_ov   = sel ? w_ov   : a_ov;
  assign o_pc   = sel ? w_pc   : a_pc;
  assign o_in   = sel ? w_in   : a_in;

  fetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(a_req), .imem_addr(a_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(a_ov), .out_ready(out_ready), .out_pc(a_pc), .out_instr(a_in));

  fetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(WRAP)) dut_w (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(w_ov), .out_ready(out_ready), .out_pc(w_pc), .out_instr(w_in));

  int n_assert = 0;
  int n_fail   = 0;
  int cyc = 0, rel = 0;
  int first_req, first_valid, req_cnt, gap_cnt;
  logic        m_req;
  logic [31:0] m_addr, exp_pc;
  logic [31:0] exp_pc_q[$], exp_in_q[$], pop_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic log_chk(input string tag, input int idx, input logic [31:0] exp);
    chk({tag, "_present"}, 32'(pop_log.size() > idx), 32'd1);
    if (pop_log.size() > idx) chk(tag, pop_log[idx], exp);
  endtask

  // Per-cycle observer, sampled on the falling edge.
  task automatic monitor();
    cyc++;
    if (!rst) begin
      exp_pc = sel ? WRAP : 32'h0;
      exp_pc_q.delete(); exp_in_q.delete(); pop_log.delete();
      first_req = -1; first_valid = -1; req_cnt = 0; gap_cnt = 0;
      m_req = 1'b0;
      return;
    end
    m_req  = o_req;
    m_addr = o_addr;
    if (redirect_valid) begin
      chk("redir_out_valid", 32'(o_ov), 32'd0);
      chk("redir_imem_req", 32'(o_req), 32'd0);
      exp_pc_q.delete(); exp_in_q.delete(); pop_log.delete();
      exp_pc = redirect_pc & ~32'h3;
      return;
    end
    if (o_req) begin
      chk("imem_addr", o_addr, exp_pc);
      exp_pc_q.push_back(exp_pc);
      exp_in_q.push_back(exp_pc ^ PAT);
      exp_pc = exp_pc + 32'd4;
      req_cnt++;
      if (first_req < 0) first_req = cyc;
    end
    if (o_ov) begin
      if (first_valid < 0) first_valid = cyc;
      if (out_ready) begin
        chk("sb_nonempty", 32'(exp_pc_q.size() != 0), 32'd1);
        if (exp_pc_q.size() != 0) begin
          chk("out_pc", o_pc, exp_pc_q.pop_front());
          chk("out_instr", o_in, exp_in_q.pop_front());
          pop_log.push_back(o_pc);
        end
      end
    end else begin
      chk("idle_instr", o_in, NOP);
      if (out_ready && first_valid >= 0) gap_cnt++;
    end
  endtask

  // One clock: observe, then act as the 1-cycle memory after the rising edge.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    imem_rvalid = rst && m_req;
    imem_rdata  = m_addr ^ PAT;
  endtask

  task automatic reset_seq(input logic s, input logic rdy);
    rst = 1'b0; sel = s; out_ready = rdy; redirect_valid = 1'b0; imem_rvalid = 1'b0;
    cycle(); cycle();
    rel = cyc;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b1;
    m_req = 1'b0; m_addr = '0; exp_pc = '0;
    #2;
    chk("rst_imem_req", 32'(o_req), 32'd0);
    chk("rst_out_valid", 32'(o_ov), 32'd0);
    chk("rst_out_pc", o_pc, 32'h0);
    chk("rst_out_instr", o_in, NOP);

    // 1: streaming from reset
    reset_seq(1'b0, 1'b1);
    repeat (12) cycle();
    chk("t1_first_req", 32'(first_req), 32'(rel + 1));
    chk("t1_latency", 32'(first_valid - first_req), 32'(LAT));
    log_chk("t1_pc0", 0, 32'h0);
    log_chk("t1_pc1", 1, 32'h4);
    log_chk("t1_pc2", 2, 32'h8);
    chk("t1_gaps", 32'(gap_cnt), 32'd0);

    // 2: stall until full, then drain and refill
    reset_seq(1'b0, 1'b0);
    repeat (10) cycle();
    chk("t2_req_cnt", 32'(req_cnt), 32'd4);
    chk("t2_req_stalled", 32'(o_req), 32'd0);
    chk("t2_valid_held", 32'(o_ov), 32'd1);
    chk("t2_head_pc", o_pc, 32'h0);
    out_ready = 1'b1;
    repeat (8) cycle();
    log_chk("t2_pc0", 0, 32'h0);
    log_chk("t2_pc1", 1, 32'h4);
    log_chk("t2_pc2", 2, 32'h8);
    log_chk("t2_pc3", 3, 32'hC);
    log_chk("t2_pc4", 4, 32'h10);
    chk("t2_gaps", 32'(gap_cnt), 32'd0);

    // 3: redirect with three entries queued and one request in flight
    reset_seq(1'b0, 1'b0);
    repeat (4) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; out_ready = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    repeat (6) cycle();
    log_chk("t3_pc0", 0, 32'h100);
    log_chk("t3_pc1", 1, 32'h104);

    // 4: back-to-back redirects, last one wins
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect_pc = 32'h300;
    cycle();
    redirect_valid = 1'b0;
    repeat (6) cycle();
    log_chk("t4_pc0", 0, 32'h300);
    log_chk("t4_pc1", 1, 32'h304);

    // 5: address wrap from a high reset PC
    reset_seq(1'b1, 1'b1);
    repeat (8) cycle();
    log_chk("t5_pc0", 0, 32'hFFFF_FFF8);
    log_chk("t5_pc1", 1, 32'hFFFF_FFFC);
    log_chk("t5_pc2", 2, 32'h0000_0000);
    chk("t5_gaps", 32'(gap_cnt), 32'd0);

    // 6: asynchronous reset mid-stream
    reset_seq(1'b0, 1'b0);
    repeat (3) cycle();
    chk("t6_pre_valid", 32'(o_ov), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_imem_req", 32'(o_req), 32'd0);
    chk("t6_out_valid", 32'(o_ov), 32'd0);
    chk("t6_out_pc", o_pc, 32'h0);
    chk("t6_out_instr", o_in, NOP);
    imem_rvalid = 1'b0;
    m_req = 1'b0;
    reset_seq(1'b0, 1'b1);
    repeat (6) cycle();
    chk("t6_first_req", 32'(first_req), 32'(rel + 1));
    log_chk("t6_pc0", 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
